// File: rtl/m81.sv
// Registered 8:1 multiplexer: {a,b,c} selects one of Y0..Y7 and the chosen bit
// is captured into out on each rising clock edge.
module m81 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Y0,
    input  logic Y1,
    input  logic Y2,
    input  logic Y3,
    input  logic Y4,
    input  logic Y5,
    input  logic Y6,
    input  logic Y7,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic out
);

    logic [2:0] w_sel;
    logic       w_next;
    logic       r_out;

    assign w_sel = {a, b, c};

    // An unknown select code falls through to the default branch and yields 0.
    always_comb begin
        w_next = 1'b0;
        case (w_sel)
            3'd0:    w_next = Y0;
            3'd1:    w_next = Y1;
            3'd2:    w_next = Y2;
            3'd3:    w_next = Y3;
            3'd4:    w_next = Y4;
            3'd5:    w_next = Y5;
            3'd6:    w_next = Y6;
            3'd7:    w_next = Y7;
            default: w_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= RST_VAL;
        end else begin
            r_out <= w_next;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_m81.sv
// Directed self-checking bench for the m81 registered 8:1 multiplexer.
module tb_m81;

    logic       clk;
    logic       rst_n;
    logic [7:0] yVec;
    logic       a;
    logic       b;
    logic       c;
    logic       out;

    int checkCount;
    int failCount;

    m81 #(.RST_VAL(1'b0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Y0   (yVec[0]),
        .Y1   (yVec[1]),
        .Y2   (yVec[2]),
        .Y3   (yVec[3]),
        .Y4   (yVec[4]),
        .Y5   (yVec[5]),
        .Y6   (yVec[6]),
        .Y7   (yVec[7]),
        .a    (a),
        .b    (b),
        .c    (c),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: out=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive data and select, let one rising edge capture them, then sample on the falling edge.
    task automatic applyStimulus(input logic [7:0] yVal, input logic [2:0] selVal);
        yVec = yVal;
        {a, b, c} = selVal;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] sweepExp;

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n = 1'b0;
        yVec  = 8'h80;
        {a, b, c} = 3'b111;
        sweepExp = 8'b1010_0110;

        // Reset held with Y7=1 selected: out must stay at RST_VAL across edges.
        #1;
        checkOutput("reset_initial", out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_hold", out, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_release", out, 1'b1);

        // Sweep all select codes; before the edge out still holds the previous result.
        for (int s = 0; s < 8; s++) begin
            yVec = 8'b1010_0110;
            {a, b, c} = 3'(s);
            #1;
            if (s > 0) checkOutput("sweep_pre_edge", out, sweepExp[s-1]);
            @(posedge clk);
            @(negedge clk);
            checkOutput("sweep", out, sweepExp[s]);
        end

        // Walking one across every data input and every select code.
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                applyStimulus(8'(1 << k), 3'(j));
                checkOutput("walk_one", out, (j == k) ? 1'b1 : 1'b0);
            end
        end

        // Isolation: Y2 held high while every other input toggles.
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i % 2 == 0) ? 8'b1111_1111 : 8'b0000_0100, 3'b010);
            checkOutput("isolation", out, 1'b1);
        end

        // Simultaneous select and data change lands on the new input's new value.
        applyStimulus(8'b0000_0000, 3'b011);
        checkOutput("simul_before", out, 1'b0);
        applyStimulus(8'b0100_0000, 3'b110);
        checkOutput("simul_after", out, 1'b1);

        // Asynchronous reset between edges clears out without a clock.
        checkOutput("async_pre", out, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_assert", out, 1'b0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("async_flight_discard", out, 1'b1);

        // Unknown select bit: out defaults to 0, then recovers on a valid code.
        applyStimulus(8'b0010_0000, 3'b101);
        checkOutput("xsel_pre", out, 1'b1);
        yVec = 8'b0010_0000;
        a = 1'bx;
        b = 1'b0;
        c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("xsel_unknown", out, 1'b0);
        a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("xsel_recover", out, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/m81.md
M81 -- requirements
Module: m81

Interface
REQ-001 Parameter RST_VAL, default 1'b0, SHALL set the value loaded into out on reset.
REQ-002 Port clk, input, 1 bit, SHALL be the single rising-edge clock for all state.
REQ-003 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Ports Y0..Y7, input, 1 bit each, SHALL be the eight data inputs; Yk is selected when the select code equals k.
REQ-005 Port a, input, 1 bit, SHALL be select bit 2 (MSB).
REQ-006 Port b, input, 1 bit, SHALL be select bit 1.
REQ-007 Port c, input, 1 bit, SHALL be select bit 0 (LSB).
REQ-008 Port out, output, 1 bit, SHALL be the registered multiplexer result.
REQ-009 All ports SHALL be connectable by name using exactly these identifiers.

Function
REQ-010 The select code SHALL be the concatenation {a,b,c} as a 3-bit unsigned value 0..7, not any reduction (AND/OR) of a, b and c.
REQ-011 The combinational next value SHALL be: 000->Y0, 001->Y1, 010->Y2, 011->Y3, 100->Y4, 101->Y5, 110->Y6, 111->Y7.
REQ-012 On each rising clk edge with rst_n high, out SHALL load the next value; latency SHALL be exactly 1 clock from a stable input/select to out.
REQ-013 out SHALL change only on a rising clk edge or on rst_n assertion, and SHALL never follow input glitches between edges.
REQ-014 If any select bit is X or Z at a clock edge, out SHALL load 1'b0 (default branch).
REQ-015 Simultaneous select and data changes before the same edge SHALL produce the newly selected input's new value after that edge.
REQ-016 Unselected inputs toggling SHALL NOT affect out.
REQ-017 The block SHALL contain no other state and SHALL produce no outputs other than out.

Reset
REQ-018 When rst_n falls, out SHALL take RST_VAL immediately, without waiting for clk.
REQ-019 While rst_n is low, out SHALL hold RST_VAL regardless of clk, Y0..Y7, a, b and c.
REQ-020 On the first rising clk edge after rst_n rises, out SHALL load the selected input normally.
REQ-021 If rst_n is asserted mid-operation, the next value in flight SHALL be discarded.

Verification
REQ-022 Reset: rst_n=0 with Y7=1, {a,b,c}=111, clk toggling -> out=0 throughout; rst_n=1, then one edge -> out=1.
REQ-023 Sweep: Y=8'b1010_0110 (Y7..Y0), step {a,b,c} 0..7 one code per cycle -> out = 0,1,1,0,0,1,0,1, each appearing one cycle after its select.
REQ-024 Walking one: only Yk=1, select k -> out=1; select any j!=k -> out=0, for all k.
REQ-025 Isolation: {a,b,c}=010, Y2=1 held, toggle all other Y every cycle -> out stays 1.
REQ-026 Async reset: rst_n pulsed low between clock edges with out=1 -> out=0 before the next edge.
REQ-027 X select: a=X at an edge -> out=0; a=1, b=0, c=1 at the next edge -> out=Y5.
